fetch_exec_sequencer: RTL and testbench
=======================================

Name: fetch_exec_sequencer

Overview:
- Multi-cycle control FSM that fetches 8-bit instructions from program memory and drives the four 2-4 instruction decoders.
- Sequences fetch/decode/execute so decoder outputs are asserted only during a bounded execute window. At all other times it drives the all-nop control word.
- Sits between program memory and the instruction_decoder array; owns the program counter.

Parameters:
- PC_W, 4, program counter width; wraps modulo 2^PC_W.
- EXEC_CYCLES, 2, un-stalled execute cycles per instruction; legal range 1-15.
- NOP_WORD, 8'h40, decoder input byte selecting every decoder's nop pin: dec1=01, dec2=00, dec3=00, dec4=00.
- HALT_OP, 8'h40, instruction value that halts the sequencer.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; starts execution from IDLE or HALTED
- instr_req  output  1  fetch request to program memory
- pc  output  PC_W  fetch address, valid while instr_req=1
- instr_data  input  8  fetched instruction
- instr_valid  input  1  instr_data valid; honoured only while instr_req=1
- stall  input  1  datapath busy; freezes execute
- ctrl_word  output  8  to decoders: [7:6] dec1, [5:4] dec2, [3:2] dec3, [1:0] dec4
- ctrl_active  output  1  high when ctrl_word carries the instruction, not NOP_WORD
- busy  output  1  high in FETCH, DECODE, EXEC
- halted  output  1  high in HALTED

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, ir=NOP_WORD, exec_cnt=0, instr_req=0, busy=0, halted=0.
- ctrl_word and ctrl_active are combinational from state, ir and stall: ctrl_word = ir and ctrl_active=1 only when state==EXEC and stall==0; otherwise ctrl_word=NOP_WORD and ctrl_active=0.
- All other state is registered.
- IDLE: on start=1 go to FETCH.
- FETCH:
  - instr_req=1 and pc stable.
  - On an edge with instr_valid=1, ir<=instr_data and go to DECODE.
  - No timeout; waits indefinitely.
- DECODE: exactly 1 cycle.
  - If ir==HALT_OP, go to HALTED; pc is not incremented.
  - Otherwise exec_cnt<=0 and go to EXEC.
- EXEC:
  - Each cycle with stall=0 counts as one executed cycle (exec_cnt+1).
  - Stalled cycles output NOP_WORD and do not count.
  - On the edge completing the EXEC_CYCLES-th un-stalled cycle: pc<=pc+1 (wraps from 2^PC_W-1 to 0) and go to FETCH.
- HALTED: halted=1. On start=1, pc<=0 and go to FETCH.
- start is ignored in FETCH, DECODE and EXEC. instr_valid is ignored outside FETCH.
- Minimum instruction period: 1 (FETCH with instr_valid already high) + 1 DECODE + EXEC_CYCLES.
- Reset asserted mid-EXEC drops ctrl_word to NOP_WORD immediately (combinational path through state). No partial pc increment.
- Stall asserted in the last EXEC cycle: the cycle does not count, so the instruction is extended.

Decomposition:
- Shared package: NOP_WORD, HALT_OP default, state enum (IDLE, FETCH, DECODE, EXEC, HALTED), ctrl_word field slice constants for dec1-dec4.
- Single module, no sub-modules. The decoder array is instantiated beside it, not inside.

Test Plan:
- Reset then start; memory returns 8'h9C with instr_valid in the first FETCH cycle -> DECODE next cycle; ctrl_word=8'h9C with ctrl_active=1 for exactly 2 cycles; pc 0->1; instr_req reasserts.
- stall=1 during the first EXEC cycle of 8'h9C -> that cycle shows ctrl_word=8'h40, ctrl_active=0; 8'h9C then appears for 2 further cycles; instruction spans 3 EXEC cycles.
- Program {8'h11, 8'h40} -> 8'h11 executes; HALT_OP is fetched at pc=1; halted=1, pc stays 1, ctrl_word=8'h40; start -> pc=0, FETCH.
- PC_W=4, 16 non-halt instructions -> pc goes 15->0 and fetch continues at 0.
- rst pulsed mid-EXEC -> same cycle ctrl_word=8'h40; after release state=IDLE, pc=0, busy=0, halted=0.
- instr_valid pulsed in IDLE and EXEC, and start pulsed in EXEC -> no state, ir or pc change.

Source files
------------

// File: rtl/fetch_exec_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_exec_sequencer_pkg
//  Description : Shared constants and state encoding for the fetch/execute
//                sequencer that drives the 2-4 instruction decoder array.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_exec_sequencer_pkg;

    // Decoder input byte that selects every decoder's nop pin
    // (dec1=01, dec2=00, dec3=00, dec4=00).
    localparam logic [7:0] NOP_WORD_DEFAULT = 8'h40;

    // Instruction value that stops the sequencer.
    localparam logic [7:0] HALT_OP_DEFAULT  = 8'h40;

    // Bit positions of each decoder's 2-bit field inside ctrl_word.
    localparam int DEC1_MSB = 7;
    localparam int DEC1_LSB = 6;
    localparam int DEC2_MSB = 5;
    localparam int DEC2_LSB = 4;
    localparam int DEC3_MSB = 3;
    localparam int DEC3_LSB = 2;
    localparam int DEC4_MSB = 1;
    localparam int DEC4_LSB = 0;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

endpackage : fetch_exec_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_exec_sequencer
//  Description : Multi-cycle fetch/decode/execute control FSM. Owns the
//                program counter, fetches instruction bytes from program
//                memory and presents them to the decoder array only during
//                un-stalled execute cycles; the nop word is driven otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_exec_sequencer
    import fetch_exec_sequencer_pkg::*;
#(
    parameter int         PC_W        = 4,
    parameter int         EXEC_CYCLES = 2,
    parameter logic [7:0] NOP_WORD    = NOP_WORD_DEFAULT,
    parameter logic [7:0] HALT_OP     = HALT_OP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] pc,
    input  logic [7:0]      instr_data,
    input  logic            instr_valid,
    input  logic            stall,
    output logic [7:0]      ctrl_word,
    output logic            ctrl_active,
    output logic            busy,
    output logic            halted
);

    localparam logic [3:0]      EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [7:0]      ir, ir_nxt;
    logic [3:0]      exec_cnt, exec_cnt_nxt;

    // State and datapath registers; asynchronous reset returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= NOP_WORD;
            exec_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            exec_cnt <= exec_cnt_nxt;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = ir;
        exec_cnt_nxt = exec_cnt;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_nxt    = instr_data;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // A halt leaves pc pointing at the halt instruction.
                if (ir == HALT_OP) begin
                    state_nxt = ST_HALTED;
                end else begin
                    exec_cnt_nxt = '0;
                    state_nxt    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Stalled cycles neither count nor advance the program.
                if (!stall) begin
                    if (exec_cnt == EXEC_LAST) begin
                        pc_nxt    = pc + PC_ONE;
                        state_nxt = ST_FETCH;
                    end else begin
                        exec_cnt_nxt = exec_cnt + 4'd1;
                    end
                end
            end
            ST_HALTED: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs and the decoder control word, decoded from current state.
    always_comb begin
        instr_req   = (state == ST_FETCH);
        busy        = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
        halted      = (state == ST_HALTED);
        ctrl_active = (state == ST_EXEC) && !stall;
        ctrl_word   = ctrl_active ? ir : NOP_WORD;
    end

endmodule : fetch_exec_sequencer
`default_nettype wire

// File: tb/tb_fetch_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_exec_sequencer
//  Description : Directed self-checking bench for fetch_exec_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       instr_req;
    logic [3:0] pc;
    logic [7:0] instr_data = 8'h00;
    logic       instr_valid = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] ctrl_word;
    logic       ctrl_active;
    logic       busy;
    logic       halted;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_exec_sequencer #(
        .PC_W        (4),
        .EXEC_CYCLES (2),
        .NOP_WORD    (8'h40),
        .HALT_OP     (8'h40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr_req   (instr_req),
        .pc          (pc),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .stall       (stall),
        .ctrl_word   (ctrl_word),
        .ctrl_active (ctrl_active),
        .busy        (busy),
        .halted      (halted)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance across one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs while sitting in a given phase.
    task automatic check_fetch(input string tag, input logic [3:0] exp_pc);
        check({tag, " req"},  instr_req, 1);
        check({tag, " pc"},   pc, exp_pc);
        check({tag, " busy"}, busy, 1);
        check({tag, " ctrl"}, ctrl_word, 8'h40);
    endtask

    task automatic check_exec(input string tag, input logic [7:0] exp_ir);
        check({tag, " ctrl"},   ctrl_word, exp_ir);
        check({tag, " active"}, ctrl_active, 1);
        check({tag, " req"},    instr_req, 0);
    endtask

    // From FETCH: return one un-stalled instruction and end back in FETCH.
    task automatic run_instr(input logic [7:0] op, input logic [3:0] exp_next_pc);
        instr_data  = op;
        instr_valid = 1'b1;
        tick();                         // -> DECODE
        instr_valid = 1'b0;
        tick();                         // -> EXEC cycle 1
        check_exec("run e1", op);
        tick();                         // -> EXEC cycle 2
        check_exec("run e2", op);
        tick();                         // -> FETCH
        check_fetch("run next", exp_next_pc);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        check("rst pc", pc, 0);
        check("rst req", instr_req, 0);
        check("rst busy", busy, 0);
        check("rst halted", halted, 0);
        check("rst ctrl", ctrl_word, 8'h40);
        check("rst active", ctrl_active, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- instr_valid in IDLE is ignored ----
        instr_data  = 8'h55;
        instr_valid = 1'b1;
        tick();
        check("idle valid busy", busy, 0);
        check("idle valid req", instr_req, 0);
        check("idle valid pc", pc, 0);
        instr_valid = 1'b0;

        // ---- basic instruction 9C, memory answers immediately ----
        start       = 1'b1;
        instr_data  = 8'h9C;
        instr_valid = 1'b1;
        tick();                         // IDLE -> FETCH
        start = 1'b0;
        check_fetch("t1 fetch", 4'd0);
        tick();                         // FETCH -> DECODE
        instr_valid = 1'b0;
        check("t1 dec req", instr_req, 0);
        check("t1 dec busy", busy, 1);
        check("t1 dec ctrl", ctrl_word, 8'h40);
        check("t1 dec active", ctrl_active, 0);
        tick();
        check_exec("t1 e1", 8'h9C);
        tick();
        check_exec("t1 e2", 8'h9C);
        tick();
        check_fetch("t1 done", 4'd1);
        check("t1 done active", ctrl_active, 0);

        // ---- stall in first EXEC cycle stretches the instruction ----
        instr_data  = 8'h9C;
        instr_valid = 1'b1;
        tick();                         // -> DECODE
        instr_valid = 1'b0;
        tick();                         // -> EXEC
        stall = 1'b1;
        #1;
        check("t2 stall ctrl", ctrl_word, 8'h40);
        check("t2 stall active", ctrl_active, 0);
        tick();
        stall = 1'b0;
        #1;
        check_exec("t2 e1", 8'h9C);
        tick();
        check_exec("t2 e2", 8'h9C);
        tick();
        check_fetch("t2 done", 4'd2);

        // ---- stall in the last EXEC cycle also extends ----
        instr_data  = 8'h9C;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check_exec("t3 e1", 8'h9C);
        tick();
        stall = 1'b1;
        #1;
        check("t3 stall ctrl", ctrl_word, 8'h40);
        tick();
        stall = 1'b0;
        #1;
        check("t3 still exec", busy, 1);
        check("t3 still req", instr_req, 0);
        check_exec("t3 e2", 8'h9C);
        tick();
        check_fetch("t3 done", 4'd3);

        // ---- async reset mid-EXEC ----
        instr_data  = 8'h11;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check_exec("t4 pre", 8'h11);
        rst = 1'b1;
        #1;
        check("t4 rst ctrl", ctrl_word, 8'h40);
        check("t4 rst active", ctrl_active, 0);
        check("t4 rst pc", pc, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t4 after busy", busy, 0);
        check("t4 after halted", halted, 0);
        check("t4 after req", instr_req, 0);
        check("t4 after pc", pc, 0);

        // ---- program {11, 40}: halt at pc=1 ----
        start = 1'b1;
        tick();
        start = 1'b0;
        check_fetch("t5 fetch0", 4'd0);
        run_instr(8'h11, 4'd1);
        instr_data  = 8'h40;
        instr_valid = 1'b1;
        tick();                         // -> DECODE
        instr_valid = 1'b0;
        tick();                         // -> HALTED
        check("t5 halted", halted, 1);
        check("t5 pc", pc, 1);
        check("t5 busy", busy, 0);
        check("t5 ctrl", ctrl_word, 8'h40);
        check("t5 req", instr_req, 0);
        tick();
        check("t5 stays halted", halted, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_fetch("t5 restart", 4'd0);
        check("t5 restart halted", halted, 0);

        // ---- start and instr_valid ignored during EXEC ----
        instr_data  = 8'h22;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();                         // EXEC cycle 1
        start       = 1'b1;
        instr_data  = 8'h33;
        instr_valid = 1'b1;
        tick();                         // EXEC cycle 2
        start       = 1'b0;
        instr_valid = 1'b0;
        check_exec("t6 ir kept", 8'h22);
        check("t6 pc kept", pc, 0);
        tick();
        check_fetch("t6 done", 4'd1);

        // ---- pc wraps 15 -> 0 ----
        for (int i = 1; i < 16; i++) begin
            run_instr(8'h80 + 8'(i), 4'((i + 1) % 16));
        end
        check_fetch("t7 wrapped", 4'd0);
        run_instr(8'hA5, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_exec_sequencer
`default_nettype wire
